// File: rtl/banked_register_file_sb.sv
// -----------------------------------------------------------------------------
// banked_register_file_sb
//
// Datapath register file with N_RD combinational read ports, one ALU write
// port and one RAM-load writeback port (valid/ready). A per-register pending
// scoreboard (busy_mask) marks registers whose RAM load has been issued but
// not yet written back, so upstream control can stall on them. A two-state
// clear FSM zeroes the array one register per cycle without using reset.
//
// Optional build macro:
//   ZERO_REG_EN - register 0 is hard-wired to zero (reads 0 with rd_valid=1,
//                 ALU writes discarded, loads never mark it pending,
//                 writebacks to it complete but drop data and flag err).
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high; clears array, scoreboard and FSM
//   rd_addr      N_RD packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data      N_RD packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid     per read port: data usable (not pending, FSM idle)
//   wr_en        ALU write request
//   wr_addr      ALU write address
//   wr_data      ALU write data
//   ld_issue     RAM load issued; marks ld_addr pending
//   ld_addr      destination register of the issued load
//   ld_wb_valid  load writeback valid
//   ld_wb_ready  load writeback ready (high while idle)
//   ld_wb_addr   writeback destination register
//   ld_wb_data   writeback data
//   clr_start    request a sequential clear of the array
//   busy_mask    registered pending bit per register
//   clr_busy     clear FSM active (registered)
//   err          one-cycle registered pulse after any illegal request
// -----------------------------------------------------------------------------
module banked_register_file_sb #(
  parameter int DATA_WIDTH = 16,
  parameter int N_REG      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int N_RD       = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_RD*ADDR_WIDTH-1:0]     rd_addr,
  output logic [N_RD*DATA_WIDTH-1:0]     rd_data,
  output logic [N_RD-1:0]                rd_valid,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           ld_issue,
  input  logic [ADDR_WIDTH-1:0]          ld_addr,
  input  logic                           ld_wb_valid,
  output logic                           ld_wb_ready,
  input  logic [ADDR_WIDTH-1:0]          ld_wb_addr,
  input  logic [DATA_WIDTH-1:0]          ld_wb_data,
  input  logic                           clr_start,
  output logic [N_REG-1:0]               busy_mask,
  output logic                           clr_busy,
  output logic                           err
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_REG - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   regs [N_REG];

  logic                    idle;
  logic                    wr_addr_ok;
  logic                    ld_addr_ok;
  logic                    wr_acc;
  logic                    wr_err;
  logic                    wb_fire;
  logic                    wb_acc;
  logic                    wb_err;
  logic                    wb_same_ld;
  logic                    ld_req;
  logic                    ld_set;
  logic                    ld_err;
  logic                    clr_go;
  logic                    clr_err;
  logic                    err_next;
  logic [N_REG-1:0]        busy_next;

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  assign idle        = (state == IDLE);
  assign ld_wb_ready = idle;

  // With the zero register enabled, writes and loads aimed at r0 vanish
  // silently; otherwise these terms are constant 1.
  assign wr_addr_ok  = !(ZERO_REG && (wr_addr == '0));
  assign ld_addr_ok  = !(ZERO_REG && (ld_addr == '0));

  // ALU writes only land on non-pending registers; a write to a pending
  // register would be overwritten by the outstanding load, so it is an error.
  assign wr_acc      = idle && wr_en && wr_addr_ok && !busy_mask[wr_addr];
  assign wr_err      = idle && wr_en && busy_mask[wr_addr];

  // The handshake always completes when ready; only a writeback to a pending
  // register actually updates state. r0 is never pending in zero-reg mode, so
  // a writeback there falls into the error path automatically.
  assign wb_fire     = ld_wb_valid && ld_wb_ready;
  assign wb_acc      = wb_fire && busy_mask[ld_wb_addr];
  assign wb_err      = wb_fire && !busy_mask[ld_wb_addr];
  assign wb_same_ld  = wb_acc && (ld_wb_addr == ld_addr);

  // A load may be re-issued to a register only if its previous load retires
  // in the same cycle; the bit then ends up set for the new load.
  assign ld_req      = idle && ld_issue && ld_addr_ok;
  assign ld_set      = ld_req && (!busy_mask[ld_addr] || wb_same_ld);
  assign ld_err      = ld_req && busy_mask[ld_addr] && !wb_same_ld;

  assign clr_go      = idle && clr_start && (busy_mask == '0);
  assign clr_err     = idle && clr_start && (busy_mask != '0);

  assign err_next    = wr_err || wb_err || ld_err || clr_err;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_next = busy_mask;
    if (wb_acc) busy_next[ld_wb_addr] = 1'b0;
    if (ld_set) busy_next[ld_addr]    = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // NOTE: the array is reset explicitly because reset must leave every
  // register reading zero; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REG; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[clr_cnt] <= '0;
    end else begin
      // wr_acc and wb_acc never target the same register: one requires the
      // register pending, the other requires it not pending.
      if (wr_acc) regs[wr_addr]    <= wr_data;
      if (wb_acc) regs[ld_wb_addr] <= ld_wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard, error pulse and clear FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      clr_busy  <= 1'b0;
      busy_mask <= '0;
      err       <= 1'b0;
    end else begin
      err       <= err_next;
      busy_mask <= busy_next;
      case (state)
        IDLE: begin
          if (clr_go) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          // One register per cycle; the last index returns to IDLE so CLEAR
          // lasts exactly N_REG cycles.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with same-cycle bypass
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;

    assign addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data  = regs[addr];
      valid = idle && (!busy_mask[addr] || (wb_acc && (ld_wb_addr == addr)));
      // ALU bypass wins over writeback bypass; both can never hit the same
      // address in one cycle, so the order only documents intent.
      if (wr_acc && (wr_addr == addr)) begin
        data = wr_data;
      end else if (wb_acc && (ld_wb_addr == addr)) begin
        data = ld_wb_data;
      end
      if (ZERO_REG && (addr == '0)) begin
        data  = '0;
        valid = 1'b1;
      end
    end

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_valid[k]                         = valid;
  end

endmodule

// File: tb/tb_banked_register_file_sb.sv
// -----------------------------------------------------------------------------
// tb_banked_register_file_sb
//
// Directed test of banked_register_file_sb in its default build (r0 is an
// ordinary register). Inputs change 1 time unit after the rising edge and
// outputs are sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_banked_register_file_sb;

  localparam int DW = 16;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int NP = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_valid;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              ld_issue;
  logic [AW-1:0]     ld_addr;
  logic              ld_wb_valid;
  logic              ld_wb_ready;
  logic [AW-1:0]     ld_wb_addr;
  logic [DW-1:0]     ld_wb_data;
  logic              clr_start;
  logic [NR-1:0]     busy_mask;
  logic              clr_busy;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  banked_register_file_sb #(
    .DATA_WIDTH (DW),
    .N_REG      (NR),
    .ADDR_WIDTH (AW),
    .N_RD       (NP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ld_issue    (ld_issue),
    .ld_addr     (ld_addr),
    .ld_wb_valid (ld_wb_valid),
    .ld_wb_ready (ld_wb_ready),
    .ld_wb_addr  (ld_wb_addr),
    .ld_wb_data  (ld_wb_data),
    .clr_start   (clr_start),
    .busy_mask   (busy_mask),
    .clr_busy    (clr_busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  function automatic logic [DW-1:0] rdp(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  initial begin
    int          n_clr;
    logic        bad_ready;
    logic        bad_valid;
    logic        saw_err;
    logic [DW-1:0] acc;

    reset       = 1'b1;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    ld_issue    = 1'b0;
    ld_addr     = '0;
    ld_wb_valid = 1'b0;
    ld_wb_addr  = '0;
    ld_wb_data  = '0;
    clr_start   = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_mask", 32'(busy_mask), 32'h0);
    check("rst_clr_busy", 32'(clr_busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_wb_ready", 32'(ld_wb_ready), 32'h1);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h7);
    reset = 1'b0;

    // ---- ALU write with same-cycle bypass ----
    set_rd(4'd5, 4'd5, 4'd2);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    #1;
    check("wr_bypass_data", 32'(rdp(0)), 32'hBEEF);
    check("wr_bypass_valid", 32'(rd_valid), 32'h7);
    tick();
    wr_en = 1'b0;
    #1;
    check("wr_array_p0", 32'(rdp(0)), 32'hBEEF);
    check("wr_array_p1", 32'(rdp(1)), 32'hBEEF);
    check("wr_other_p2", 32'(rdp(2)), 32'h0);

    // ---- load issue then writeback ----
    ld_issue = 1'b1; ld_addr = 4'd3;
    tick();
    ld_issue = 1'b0;
    set_rd(4'd3, 4'd5, 4'd5);
    #1;
    check("ld_pending_valid", 32'(rd_valid), 32'h6);
    check("ld_pending_mask", 32'(busy_mask), 32'h0008);
    ld_wb_valid = 1'b1; ld_wb_addr = 4'd3; ld_wb_data = 16'h1234;
    #1;
    check("wb_ready", 32'(ld_wb_ready), 32'h1);
    check("wb_bypass_data", 32'(rdp(0)), 32'h1234);
    check("wb_bypass_valid", 32'(rd_valid), 32'h7);
    tick();
    ld_wb_valid = 1'b0;
    #1;
    check("wb_mask_cleared", 32'(busy_mask), 32'h0);
    check("wb_array_data", 32'(rdp(0)), 32'h1234);
    check("wb_no_err", 32'(err), 32'h0);

    // ---- ALU write to a pending register ----
    ld_issue = 1'b1; ld_addr = 4'd3;
    tick();
    ld_issue = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hAAAA;
    #1;
    check("wr_pend_no_bypass", 32'(rdp(0)), 32'h1234);
    check("wr_pend_invalid", 32'(rd_valid[0]), 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    check("wr_pend_err", 32'(err), 32'h1);
    check("wr_pend_unchanged", 32'(rdp(0)), 32'h1234);
    tick();
    check("wr_pend_err_pulse_end", 32'(err), 32'h0);
    ld_wb_valid = 1'b1; ld_wb_addr = 4'd3; ld_wb_data = 16'h5555;
    tick();
    ld_wb_valid = 1'b0;
    #1;
    check("wb_r3_data", 32'(rdp(0)), 32'h5555);

    // ---- writeback to a non-pending register ----
    set_rd(4'd7, 4'd3, 4'd5);
    ld_wb_valid = 1'b1; ld_wb_addr = 4'd7; ld_wb_data = 16'h7777;
    #1;
    check("wb_np_no_bypass", 32'(rdp(0)), 32'h0);
    tick();
    ld_wb_valid = 1'b0;
    #1;
    check("wb_np_err", 32'(err), 32'h1);
    check("wb_np_unchanged", 32'(rdp(0)), 32'h0);
    check("wb_np_mask", 32'(busy_mask), 32'h0);
    tick();

    // ---- simultaneous writeback and re-issue to the same register ----
    ld_issue = 1'b1; ld_addr = 4'd9;
    tick();
    set_rd(4'd9, 4'd3, 4'd5);
    ld_wb_valid = 1'b1; ld_wb_addr = 4'd9; ld_wb_data = 16'h9999;
    #1;
    check("wbld_bypass_valid", 32'(rd_valid[0]), 32'h1);
    check("wbld_bypass_data", 32'(rdp(0)), 32'h9999);
    tick();
    ld_issue = 1'b0; ld_wb_valid = 1'b0;
    #1;
    check("wbld_mask", 32'(busy_mask), 32'h0200);
    check("wbld_no_err", 32'(err), 32'h0);
    check("wbld_array", 32'(rdp(0)), 32'h9999);
    ld_wb_valid = 1'b1; ld_wb_addr = 4'd9; ld_wb_data = 16'h1111;
    tick();
    ld_wb_valid = 1'b0;
    #1;
    check("wbld_retired_mask", 32'(busy_mask), 32'h0);

    // ---- clr_start refused while a load is pending ----
    ld_issue = 1'b1; ld_addr = 4'd4;
    tick();
    ld_issue = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    #1;
    check("clr_refused_err", 32'(err), 32'h1);
    check("clr_refused_busy", 32'(clr_busy), 32'h0);
    ld_wb_valid = 1'b1; ld_wb_addr = 4'd4; ld_wb_data = 16'h4444;
    tick();
    ld_wb_valid = 1'b0;
    tick();

    // ---- fill, then sequential clear ----
    for (int i = 0; i < NR; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    set_rd(4'd0, 4'd15, 4'd8);
    #1;
    check("fill_r0", 32'(rdp(0)), 32'h1);
    check("fill_r15", 32'(rdp(1)), 32'h10);
    check("fill_r8", 32'(rdp(2)), 32'h9);

    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n_clr = 0; bad_ready = 1'b0; bad_valid = 1'b0; saw_err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!clr_busy) break;
      n_clr++;
      if (ld_wb_ready) bad_ready = 1'b1;
      if (rd_valid != '0) bad_valid = 1'b1;
      if (err) saw_err = 1'b1;
      // Requests during CLEAR must be ignored without flagging an error.
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h2222;
      ld_issue = 1'b1; ld_addr = 4'd6;
      tick();
    end
    wr_en = 1'b0; ld_issue = 1'b0;
    #1;
    check("clr_cycles", 32'(n_clr), 32'd16);
    check("clr_wb_ready_low", 32'(bad_ready), 32'h0);
    check("clr_rd_valid_low", 32'(bad_valid), 32'h0);
    check("clr_no_err", 32'(saw_err | err), 32'h0);
    check("clr_mask", 32'(busy_mask), 32'h0);
    acc = '0;
    for (int i = 0; i < NR; i++) begin
      set_rd(AW'(i), AW'(i), AW'(i));
      #1;
      acc = acc | rdp(0) | rdp(1) | rdp(2);
    end
    check("clr_all_zero", 32'(acc), 32'h0);
    check("clr_idle_valid", 32'(rd_valid), 32'h7);

    // ---- reset asserted mid-clear ----
    tick();
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'hABCD;
    tick();
    wr_en = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (4) tick();
    check("mid_clr_busy", 32'(clr_busy), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rstclr_clr_busy", 32'(clr_busy), 32'h0);
    check("rstclr_err", 32'(err), 32'h0);
    check("rstclr_mask", 32'(busy_mask), 32'h0);
    check("rstclr_wb_ready", 32'(ld_wb_ready), 32'h1);
    set_rd(4'd15, 4'd15, 4'd15);
    #1;
    check("rstclr_r15_zero", 32'(rdp(0)), 32'h0);
    check("rstclr_rd_valid", 32'(rd_valid), 32'h7);
    #1;
    reset = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'h0F0F;
    tick();
    wr_en = 1'b0;
    #1;
    check("post_rst_write", 32'(rdp(0)), 32'h0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_register_file_sb.md
Name: banked_register_file_sb

Overview:
Parametrised register file for the processor datapath: N_RD combinational read ports, one ALU write port and one RAM-load writeback port with a valid/ready handshake. A per-register pending scoreboard flags registers awaiting RAM loads, so that upstream control can stall. A sequential clear FSM zeroes the array on request without asserting reset.

Parameters:
DATA_WIDTH, 16, bits per register
N_REG, 16, number of registers (power of two, >=2)
ADDR_WIDTH, 4, register address width; must equal log2(N_REG)
N_RD, 3, number of read ports (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears array, scoreboard and FSM
rd_addr  in  N_RD*ADDR_WIDTH  read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  N_RD*DATA_WIDTH  read data, same slicing
rd_valid  out  N_RD  1 = rd_data[k] is usable (register not pending, FSM in IDLE)
wr_en  in  1  ALU write request
wr_addr  in  ADDR_WIDTH  ALU write address
wr_data  in  DATA_WIDTH  ALU write data
ld_issue  in  1  RAM load issued; marks ld_addr pending
ld_addr  in  ADDR_WIDTH  destination of the issued load
ld_wb_valid  in  1  load writeback valid
ld_wb_ready  out  1  load writeback ready
ld_wb_addr  in  ADDR_WIDTH  writeback address
ld_wb_data  in  DATA_WIDTH  writeback data
clr_start  in  1  start sequential clear
busy_mask  out  N_REG  registered pending bits
clr_busy  out  1  clear FSM active
err  out  1  one-cycle pulse, registered, one cycle after an illegal request

Behaviour:
- Reset values: all registers 0, busy_mask 0, FSM IDLE, clr_busy 0, err 0, ld_wb_ready 1.
- Read: combinational, zero latency. rd_data[k] = array[rd_addr[k]], with same-cycle bypass:
  - If an accepted ALU write targets rd_addr[k], return wr_data.
  - Else if an accepted writeback targets rd_addr[k], return ld_wb_data.
- rd_valid[k] = IDLE && (!busy_mask[rd_addr[k]] || accepted writeback to that address this cycle).
- ALU write: accepted when IDLE && !busy_mask[wr_addr]; array updated at the clock edge.
- ALU write to a pending register: dropped; err pulses the next cycle.
- ld_issue, accepted in IDLE:
  - busy_mask[ld_addr] set at the edge.
  - Issue to an already-pending address with no same-cycle writeback to it: ignored; err pulses.
- Writeback: handshake completes when ld_wb_valid && ld_wb_ready; ld_wb_ready = (state == IDLE).
  - On completion the register is written and its busy bit cleared.
  - Writeback to a non-pending address: data dropped; err pulses.
- Simultaneous writeback and ld_issue to the same address: data written; busy bit ends at 1 (new load outstanding).
- ALU write and writeback to the same address cannot both be accepted (pending rule); no priority logic is needed beyond the bypass order above.
- Clear FSM, states IDLE and CLEAR:
  - IDLE->CLEAR on clr_start when busy_mask == 0; otherwise clr_start is ignored and err pulses.
  - CLEAR zeroes one register per cycle, counter 0..N_REG-1, then returns to IDLE. Total N_REG cycles in CLEAR; clr_busy is high throughout.
  - In CLEAR: wr_en and ld_issue are ignored (no err), ld_wb_ready = 0, and all rd_valid = 0.
  - clr_start while in CLEAR is ignored.
- Reset asserted mid-CLEAR: immediate return to IDLE with everything zeroed.
- err: OR of all illegal conditions in a cycle, registered.

Optional Feature:
ZERO_REG_EN:
- Defined: register 0 always reads 0 with rd_valid = 1, including over bypass. ALU writes to 0 are silently discarded. ld_issue to 0 is ignored and busy_mask[0] stays 0. Writeback to 0 completes the handshake, discards the data and pulses err.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Write 16'hBEEF to r5 with rd_addr[0]=5 in the same cycle -> rd_data[0]=BEEF via bypass, rd_valid[0]=1; next cycle still BEEF from the array.
- ld_issue r3, then read r3 -> rd_valid=0, busy_mask=16'h0008. Writeback r3=16'h1234 -> ready=1, rd_data=1234, valid=1 that cycle; busy_mask=0 after the edge.
- ALU write to pending r3 -> r3 unchanged, err=1 one cycle later; writeback to non-pending r7 -> r7 unchanged, err pulse.
- Fill r0..r15 with i+1, then clr_start -> clr_busy high exactly 16 cycles, ld_wb_ready=0 during clear, all registers read 0 afterwards. clr_start with busy_mask!=0 -> no clear, err pulse.
- Assert reset at cycle 5 of CLEAR -> IDLE immediately, clr_busy=0, all outputs at reset values.
- ZERO_REG_EN defined: write 16'hFFFF to r0 -> reads 0; ld_issue r0 -> busy_mask[0]=0.
